lfsr_checker: RTL and testbench
===============================

Name: lfsr_checker

Overview:
- Serial PRBS receiver/checker. It consumes the bit stream produced by the team's LFSR generator at the slow divided-clock rate and self-synchronises to the sequence.
- Once locked, it counts bit errors and declares loss of lock.
- It sits at the receive end of the LFSR demo link and drives the lock and error LEDs.

Parameters:
- WIDTH, 7, LFSR length in bits (PRBS7).
- TAPS, 7'h60, feedback tap mask over the shift register (x^7+x^6+1). Bit i set means reg[i] feeds the XOR.
- LOCK_COUNT, 16, consecutive correct predictions required to declare lock.
- WINDOW, 32, number of valid bits per loss-of-lock evaluation window.
- LOSS_THRESH, 8, errors within one window that force loss of lock.
- CNT_W, 16, width of err_count and bit_count.

Ports:
- clk  in  1  system clock (25 MHz).
- rst_n  in  1  reset: synchronous, active-low; clock: clk.
- bit_valid  in  1  single-cycle strobe qualifying bit_in. Gaps of any length are allowed.
- bit_in  in  1  received serial bit.
- clear_cnt  in  1  synchronous clear of err_count and bit_count.
- locked  out  1  high while in LOCKED state.
- err_pulse  out  1  one-cycle pulse per detected bit error while locked.
- err_count  out  CNT_W  errors seen while locked, saturating.
- bit_count  out  CNT_W  valid bits checked while locked, saturating.

Behaviour:
- Only cycles with bit_valid=1 advance any state. All other cycles hold everything except err_pulse, which returns to 0.
- Shift register sr[WIDTH-1:0]. Predicted bit p = XOR-reduce(sr & TAPS). Shift rule: sr <= {sr[WIDTH-2:0], b}.
- States: FILL, HUNT, LOCKED.
- FILL:
  - Shift in b=bit_in.
  - fill counter counts valid bits. After WIDTH valid bits, go to HUNT with match_cnt=0.
- HUNT:
  - Compare p against bit_in, then shift in b=bit_in (self-synchronising).
  - Match with sr != 0: match_cnt++.
  - Mismatch, or sr == 0: match_cnt <= 0. The all-zero lockup state must never produce lock.
  - When match_cnt reaches LOCK_COUNT: go to LOCKED, clear window counters.
- LOCKED:
  - Shift in b=p (the locally generated bit), not bit_in, so a received error never propagates into later predictions.
  - Mismatch: err_pulse=1 next cycle, err_count++ (saturate at all-ones), win_err++.
  - Every valid bit: bit_count++ (saturating), win_bits++.
  - After the WINDOW-th bit of a window, both window counters reset.
  - If win_err reaches LOSS_THRESH on any bit, go to HUNT immediately: match_cnt=0, window counters cleared. The sr contents are kept.
- Latency:
  - locked rises the cycle after the bit_valid that completes LOCK_COUNT matches.
  - locked falls the cycle after the bit_valid that hits LOSS_THRESH.
  - err_pulse appears the cycle after the offending bit_valid.
- Counts are not updated in FILL or HUNT.
- clear_cnt:
  - Zeroes err_count and bit_count next cycle.
  - It takes priority over a same-cycle increment; that event is dropped from the counts.
  - err_pulse and the state machine are unaffected.
- Reset, in any state including mid-lock: state=FILL, sr=0, all counters 0, locked=0, err_pulse=0, err_count=0, bit_count=0.
- All outputs are registered.

Test Plan:
- PRBS7 from generator seed 7'h01, one bit_valid every 4 clks:
  - locked=0 through valid bit 22.
  - locked=1 the cycle after valid bit 23 (7 fill + 16 matches).
  - err_count=0 after 500 further bits; bit_count=500.
- Locked stream, flip one bit:
  - Exactly one err_pulse; err_count=1.
  - locked stays 1.
  - No further errors on subsequent correct bits.
- Continuous all-zero input for 200 bits -> locked never asserts; err_count=0.
- Locked, inject 8 flips within one 32-bit window -> locked falls the cycle after the 8th flip's bit_valid. Then resume a clean stream -> relock after 16 further bits.
- Locked, 7 flips in window A, then 7 in window B -> stays locked; err_count=14.
- Assert clear_cnt on the same cycle as a flipped bit -> err_count=0, bit_count=0, err_pulse=1.
- Pulse rst_n low mid-lock -> next cycle locked=0, counts 0. Clean stream relocks after 23 bits.
- Counter saturation with CNT_W=4 override -> err_count holds at 15.

Source files
------------

// File: rtl/lfsr_checker.sv
// Self-synchronising PRBS receiver: fills, hunts for LOCK_COUNT consecutive
// correct predictions, then free-runs locally while counting bit errors.
module lfsr_checker #(
  parameter int unsigned      WIDTH       = 7,
  parameter logic [WIDTH-1:0] TAPS        = 7'h60,
  parameter int unsigned      LOCK_COUNT  = 16,
  parameter int unsigned      WINDOW      = 32,
  parameter int unsigned      LOSS_THRESH = 8,
  parameter int unsigned      CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  localparam int unsigned FILL_W  = $clog2(WIDTH + 1);
  localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned WBITS_W = $clog2(WINDOW + 1);
  localparam int unsigned WERR_W  = $clog2(LOSS_THRESH + 1);

  typedef enum logic [1:0] {S_FILL, S_HUNT, S_LOCKED} state_t;

  state_t             r_state, w_state_next;
  logic [WIDTH-1:0]   r_sr, w_sr_next;
  logic [FILL_W-1:0]  r_fill_cnt, w_fill_next;
  logic [MATCH_W-1:0] r_match_cnt, w_match_next;
  logic [WBITS_W-1:0] r_win_bits, w_win_bits_next;
  logic [WERR_W-1:0]  r_win_err, w_win_err_next;
  logic               r_locked, r_err_pulse;
  logic [CNT_W-1:0]   r_err_count, r_bit_count;
  logic               w_pred, w_mismatch, w_err_inc, w_bit_inc;

  assign w_pred     = ^(r_sr & TAPS);
  assign w_mismatch = w_pred ^ bit_in;

  always_comb begin
    w_state_next    = r_state;
    w_sr_next       = r_sr;
    w_fill_next     = r_fill_cnt;
    w_match_next    = r_match_cnt;
    w_win_bits_next = r_win_bits;
    w_win_err_next  = r_win_err;
    w_err_inc       = 1'b0;
    w_bit_inc       = 1'b0;
    if (bit_valid) begin
      case (r_state)
        S_FILL: begin
          w_sr_next = {r_sr[WIDTH-2:0], bit_in};
          if (r_fill_cnt == FILL_W'(WIDTH - 1)) begin
            w_state_next = S_HUNT;
            w_match_next = '0;
            w_fill_next  = '0;
          end else begin
            w_fill_next = r_fill_cnt + 1'b1;
          end
        end
        S_HUNT: begin
          w_sr_next = {r_sr[WIDTH-2:0], bit_in};
          // An all-zero register predicts zeros forever, so it never counts.
          if (!w_mismatch && (r_sr != '0)) begin
            if (r_match_cnt == MATCH_W'(LOCK_COUNT - 1)) begin
              w_state_next    = S_LOCKED;
              w_match_next    = '0;
              w_win_bits_next = '0;
              w_win_err_next  = '0;
            end else begin
              w_match_next = r_match_cnt + 1'b1;
            end
          end else begin
            w_match_next = '0;
          end
        end
        S_LOCKED: begin
          // Free-run on the local prediction so line errors never propagate.
          w_sr_next = {r_sr[WIDTH-2:0], w_pred};
          w_bit_inc = 1'b1;
          w_err_inc = w_mismatch;
          if (w_mismatch && (r_win_err == WERR_W'(LOSS_THRESH - 1))) begin
            w_state_next    = S_HUNT;
            w_match_next    = '0;
            w_win_bits_next = '0;
            w_win_err_next  = '0;
          end else if (r_win_bits == WBITS_W'(WINDOW - 1)) begin
            w_win_bits_next = '0;
            w_win_err_next  = '0;
          end else begin
            w_win_bits_next = r_win_bits + 1'b1;
            w_win_err_next  = r_win_err + WERR_W'(w_mismatch);
          end
        end
        default: w_state_next = S_FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_FILL;
      r_sr        <= '0;
      r_fill_cnt  <= '0;
      r_match_cnt <= '0;
      r_win_bits  <= '0;
      r_win_err   <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
      r_bit_count <= '0;
    end else begin
      r_state     <= w_state_next;
      r_sr        <= w_sr_next;
      r_fill_cnt  <= w_fill_next;
      r_match_cnt <= w_match_next;
      r_win_bits  <= w_win_bits_next;
      r_win_err   <= w_win_err_next;
      r_locked    <= (w_state_next == S_LOCKED);
      r_err_pulse <= w_err_inc;
      if (clear_cnt) begin
        r_err_count <= '0;
        r_bit_count <= '0;
      end else begin
        if (w_err_inc && (r_err_count != '1)) r_err_count <= r_err_count + 1'b1;
        if (w_bit_inc && (r_bit_count != '1)) r_bit_count <= r_bit_count + 1'b1;
      end
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;
  assign bit_count = r_bit_count;

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: directed PRBS7 scenarios plus a randomized phase,
// all checked every cycle against a queue-based model of the checker rules.
module tb_lfsr_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, bit_valid, bit_in, clear_cnt;
  logic        locked, err_pulse, locked4, err_pulse4;
  logic [15:0] err_count, bit_count;
  logic [3:0]  err_count4, bit_count4;

  lfsr_checker dut (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in),
    .clear_cnt(clear_cnt), .locked(locked), .err_pulse(err_pulse),
    .err_count(err_count), .bit_count(bit_count)
  );

  lfsr_checker #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in),
    .clear_cnt(clear_cnt), .locked(locked4), .err_pulse(err_pulse4),
    .err_count(err_count4), .bit_count(bit_count4)
  );

  localparam int W = 7, TAPMASK = 'h60, LC = 16, WIN = 32, LT = 8;
  localparam int M_FILL = 0, M_HUNT = 1, M_LOCK = 2;

  int checks = 0, failures = 0;

  // Model: history queue of the bits held by the checker, newest at the back.
  int m_state, m_fill, m_match, m_wb, m_we, m_ec, m_bc, m_ec4, m_bc4;
  bit m_pulse;
  bit hist[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_FILL; m_fill = 0; m_match = 0; m_wb = 0; m_we = 0;
    m_ec = 0; m_bc = 0; m_ec4 = 0; m_bc4 = 0; m_pulse = 0;
    hist.delete();
    for (int i = 0; i < W; i++) hist.push_back(1'b0);
  endtask

  function automatic bit model_pred();
    bit p = 0;
    for (int i = 0; i < W; i++)
      if (((TAPMASK >> i) & 1) == 1) p ^= hist[hist.size() - 1 - i];
    return p;
  endfunction

  task automatic model_push(input bit b);
    hist.push_back(b);
    if (hist.size() > W) void'(hist.pop_front());
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_step(input bit v, input bit b, input bit clr, input bit rn);
    bit p, mis, nz;
    int ie, ib;
    if (!rn) begin
      model_reset();
      return;
    end
    ie = 0; ib = 0; m_pulse = 0;
    if (v) begin
      p = model_pred();
      mis = (p != b);
      case (m_state)
        M_FILL: begin
          model_push(b);
          m_fill++;
          if (m_fill == W) begin m_state = M_HUNT; m_match = 0; m_fill = 0; end
        end
        M_HUNT: begin
          nz = 0;
          foreach (hist[i]) if (hist[i]) nz = 1;
          if (!mis && nz) m_match++; else m_match = 0;
          model_push(b);
          if (m_match == LC) begin m_state = M_LOCK; m_match = 0; m_wb = 0; m_we = 0; end
        end
        default: begin
          model_push(p);
          ib = 1; ie = int'(mis); m_pulse = mis;
          m_we += int'(mis);
          m_wb++;
          if (m_we == LT) begin m_state = M_HUNT; m_match = 0; m_wb = 0; m_we = 0; end
          else if (m_wb == WIN) begin m_wb = 0; m_we = 0; end
        end
      endcase
    end
    if (clr) begin
      m_ec = 0; m_bc = 0; m_ec4 = 0; m_bc4 = 0;
    end else begin
      m_ec  = sat(m_ec + ie, 65535);
      m_bc  = sat(m_bc + ib, 65535);
      m_ec4 = sat(m_ec4 + ie, 15);
      m_bc4 = sat(m_bc4 + ib, 15);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(bit_valid, bit_in, clear_cnt, rst_n);
    #1;
    chk("locked",     32'(locked),     32'(m_state == M_LOCK));
    chk("err_pulse",  32'(err_pulse),  32'(m_pulse));
    chk("err_count",  32'(err_count),  m_ec);
    chk("bit_count",  32'(bit_count),  m_bc);
    chk("locked4",    32'(locked4),    32'(m_state == M_LOCK));
    chk("err_pulse4", 32'(err_pulse4), 32'(m_pulse));
    chk("err_count4", 32'(err_count4), m_ec4);
    chk("bit_count4", 32'(bit_count4), m_bc4);
  endtask

  logic [6:0] g;

  task automatic next_gen(output bit b);
    b = ^(g & 7'h60);
    g = {g[5:0], b};
  endtask

  task automatic send(input bit b, input bit clr, input int gap);
    bit_valid = 1'b1; bit_in = b; clear_cnt = clr;
    tick();
    bit_valid = 1'b0; clear_cnt = 1'b0;
    for (int i = 1; i < gap; i++) begin
      bit_in = 1'($urandom);
      tick();
    end
  endtask

  task automatic send_gen(input bit flip, input bit clr, input int gap);
    bit b;
    next_gen(b);
    send(b ^ flip, clr, gap);
  endtask

  task automatic reset_pulse(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) tick();
    rst_n = 1'b1;
  endtask

  task automatic align_window();
    for (int i = 0; i < 64 && m_wb != 0; i++) send_gen(0, 0, 1);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; clear_cnt = 1'b0;
    model_reset();

    // Reset state
    reset_pulse(3);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err_pulse", 32'(err_pulse), 0);
    chk("rst_err_count", 32'(err_count), 0);
    chk("rst_bit_count", 32'(bit_count), 0);

    // Acquisition from seed 7'h01, one valid every 4 clocks
    g = 7'h01;
    for (int i = 0; i < 22; i++) send_gen(0, 0, 4);
    chk("acq_bit22_unlocked", 32'(locked), 0);
    send_gen(0, 0, 1);
    chk("acq_bit23_locked", 32'(locked), 1);
    tick(); tick(); tick();
    for (int i = 0; i < 500; i++) send_gen(0, 0, 4);
    chk("clean500_err_count", 32'(err_count), 0);
    chk("clean500_bit_count", 32'(bit_count), 500);

    // Single flipped bit
    send_gen(1, 0, 1);
    chk("flip1_pulse", 32'(err_pulse), 1);
    chk("flip1_err_count", 32'(err_count), 1);
    chk("flip1_locked", 32'(locked), 1);
    tick();
    chk("flip1_pulse_drop", 32'(err_pulse), 0);
    for (int i = 0; i < 40; i++) send_gen(0, 0, 2);
    chk("flip1_no_more_err", 32'(err_count), 1);
    chk("flip1_still_locked", 32'(locked), 1);

    // 7 errors at the end of one window, 7 at the start of the next
    send_gen(0, 1, 1);
    chk("clear_err_count", 32'(err_count), 0);
    chk("clear_bit_count", 32'(bit_count), 0);
    align_window();
    for (int k = 0; k < 64; k++) send_gen(k >= 25 && k < 39, 0, 1);
    chk("split14_locked", 32'(locked), 1);
    chk("split14_err_count", 32'(err_count), 14);
    for (int k = 0; k < 32; k++) send_gen(k % 10 == 0 && k < 30, 0, 1);
    chk("sat_err_count", 32'(err_count), 17);
    chk("sat_err_count4", 32'(err_count4), 15);
    chk("sat_bit_count4", 32'(bit_count4), 15);

    // clear_cnt coincident with an error
    send_gen(1, 1, 1);
    chk("clr_err_err_count", 32'(err_count), 0);
    chk("clr_err_bit_count", 32'(bit_count), 0);
    chk("clr_err_pulse", 32'(err_pulse), 1);

    // Loss of lock after 8 errors in one window, then relock
    align_window();
    for (int k = 0; k < 15; k++) begin
      send_gen(k % 2 == 0, 0, 1);
      if (k == 12) chk("loss_after7_locked", 32'(locked), 1);
      if (k == 14) chk("loss_after8_unlocked", 32'(locked), 0);
    end
    for (int i = 0; i < 15; i++) send_gen(0, 0, 2);
    chk("relock15_unlocked", 32'(locked), 0);
    send_gen(0, 0, 1);
    chk("relock16_locked", 32'(locked), 1);

    // Reset mid-lock, then relock from FILL
    reset_pulse(1);
    chk("midrst_locked", 32'(locked), 0);
    chk("midrst_err_count", 32'(err_count), 0);
    chk("midrst_bit_count", 32'(bit_count), 0);
    for (int i = 0; i < 22; i++) send_gen(0, 0, $urandom_range(1, 3));
    chk("midrst_bit22_unlocked", 32'(locked), 0);
    send_gen(0, 0, 1);
    chk("midrst_bit23_locked", 32'(locked), 1);

    // All-zero stream never locks
    reset_pulse(1);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      send(1'b0, 0, $urandom_range(1, 2));
      if (locked) seen = 1;
    end
    chk("zeros_never_locked", 32'(seen), 0);
    chk("zeros_err_count", 32'(err_count), 0);

    // Randomized traffic
    reset_pulse(1);
    g = 7'($urandom_range(1, 127));
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 799) == 0) reset_pulse(1);
      send_gen($urandom_range(0, 23) == 0, $urandom_range(0, 149) == 0,
               $urandom_range(1, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
